crc_apb4_feeder: RTL and testbench
==================================

Name: crc_apb4_feeder

Overview:
- Upstream stage for the APB4 CRC16 engine: accepts a valid/ready stream of 32-bit words and issues APB4 master writes of 16-bit halfwords to the engine's DATA register.
- Spaces successive writes so each lands while the engine's 4-cycle nibble shifter is idle.
- Sits between a DMA/stream source and the CRC slave on the peripheral APB bus.

Parameters:
- DATA_ADDR, 32'h0000_000C, full APB byte address of the CRC DATA register.
- GAP_CYCLES, 3, idle cycles (psel low) inserted after each completed write before the next SETUP; 0..15.
- CNT_WIDTH, 16, width of the halfword write counter.

Ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- en_i  in  1  when low, no new beat accepted; beat in flight completes
- s_valid_i  in  1  stream beat valid
- s_ready_o  out  1  stream beat accepted when valid&ready
- s_data_i  in  32  beat data; [15:0] written first, then [31:16]
- s_half_i  in  1  beat carries only [15:0]; upper half not written
- s_last_i  in  1  final beat of a message
- paddr_o  out  32  APB address, always DATA_ADDR when psel_o=1
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  constant 1
- pwdata_o  out  32  {16'h0, halfword}
- pstrb_o  out  4  constant 4'b1111
- pprot_o  out  3  constant 3'b000
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB error
- prdata_i  in  32  unused
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse: last write of an s_last beat finished, including gap
- err_o  out  1  sticky: pslverr_i seen on a completed transfer
- err_clr_i  in  1  clears err_o
- wr_cnt_o  out  CNT_WIDTH  completed writes, saturating at all-ones; cleared on reset only

Behaviour:
- Reset: state IDLE; psel_o, penable_o, s_ready_o, done_o, err_o = 0; paddr_o, pwdata_o = 0; wr_cnt_o = 0. Asserting reset mid-transfer aborts immediately; no partial write is retried.
- States:
  - IDLE: s_ready_o = en_i. On s_valid_i&s_ready_o, capture data/half/last, set hi_pend = ~s_half_i, go to SETUP.
  - SETUP: psel=1, penable=0, pwdata = low half (or high half if second pass). Always go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1; hold all outputs until pready_i.
    - On pready_i: wr_cnt++ (saturating); if pslverr_i, set err_o.
    - Then go to WAIT (gap counter loaded with GAP_CYCLES-1), or, when GAP_CYCLES=0, take WAIT's exit action directly.
  - WAIT: psel=0. Decrement gap counter; when it reaches 0:
    - if hi_pend: clear it, select high half, go to SETUP;
    - else: done_o = last_q for this cycle, go to IDLE.
- Timing, pready=1, GAP=3, beat accepted in cycle T:
  - SETUP T+1, ACCESS T+2, WAIT T+3..T+5.
  - Second half: SETUP T+6, ACCESS T+7, WAIT T+8..T+10; done_o at T+10.
  - s_ready_o high again at T+11.
- Half beat: done_o (if last) at T+5; IDLE at T+6.
- pready wait states stretch ACCESS only; the gap is counted from transfer completion.
- s_ready_o is never high outside IDLE, so there is no input buffering and no overflow case.
- pslverr does not abort the beat; the remaining half is still written.
- err_clr_i and a new error in the same cycle: error wins, err_o stays 1.
- en_i deasserting mid-beat has no effect until IDLE.
- Stream beats with s_valid_i high and en_i low stay pending; they are not dropped.

Test Plan:
- Single full beat 32'hBEEF_1234, s_last=1, pready tied 1, GAP=3 -> writes 16'h1234 then 16'hBEEF to DATA_ADDR at T+2 and T+7; done_o pulses at T+10; wr_cnt_o=2.
- Half beat 32'hFFFF_00A5, s_half=1, s_last=1 -> exactly one write, pwdata_o=32'h0000_00A5; done_o at T+5; wr_cnt_o=1.
- pready held low 3 cycles in the first ACCESS -> psel/penable/paddr/pwdata stable throughout; WAIT begins the cycle after pready rises.
- Back-to-back valid beats 32'h0000_0001 and 32'h0000_0002 (second with s_last) -> 4 writes, each SETUP ≥ GAP_CYCLES+1 cycles after the prior ACCESS end; a single done_o, after the fourth write.
- pslverr_i=1 on the first write -> err_o=1 and second write still issued; err_clr_i pulse -> err_o=0.
- presetn asserted during ACCESS -> psel_o/penable_o drop asynchronously, busy_o=0; after release the next beat starts from a clean SETUP.

Source files
------------

// File: rtl/crc_apb4_feeder.sv
// Stream-to-APB4 feeder for the CRC16 engine: splits 32-bit beats into halfword
// writes to the DATA register, spacing them so the engine's nibble shifter is idle.
module crc_apb4_feeder #(
  parameter logic [31:0] DATA_ADDR  = 32'h0000_000C,
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 en_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [31:0]          s_data_i,
  input  logic                 s_half_i,
  input  logic                 s_last_i,
  output logic [31:0]          paddr_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [31:0]          pwdata_o,
  output logic [3:0]           pstrb_o,
  output logic [2:0]           pprot_o,
  input  logic                 pready_i,
  input  logic                 pslverr_i,
  input  logic [31:0]          prdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic                 err_clr_i,
  output logic [CNT_WIDTH-1:0] wr_cnt_o
);

  localparam int unsigned GW = 4;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT} state_t;

  state_t        state_q;
  logic [15:0]   hi_q;
  logic          hi_pend_q;
  logic          last_q;
  logic [GW-1:0] gap_q;

  logic xfer_done_c;
  logic exit_c;
  logic done_set_c;
  logic unused_prdata;

  assign pwrite_o      = 1'b1;
  assign pstrb_o       = 4'b1111;
  assign pprot_o       = 3'b000;
  assign busy_o        = (state_q != IDLE);
  assign unused_prdata = ^prdata_i;

  // Write completes on the ACCESS cycle with pready; the gap runs from there.
  assign xfer_done_c = (state_q == ACCESS) && pready_i;
  assign exit_c      = ((state_q == WAIT) && (gap_q == '0)) ||
                       (xfer_done_c && (GAP_CYCLES == 0));
  // done_o is registered, so it is armed one cycle ahead of the final gap cycle.
  assign done_set_c  = !hi_pend_q && last_q &&
                       (((state_q == WAIT) && (gap_q == GW'(1))) ||
                        (xfer_done_c && (GAP_CYCLES <= 1)));

  // Beat sequencing and APB request generation.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      s_ready_o <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      hi_q      <= '0;
      hi_pend_q <= 1'b0;
      last_q    <= 1'b0;
      gap_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid_i && s_ready_o) begin
            s_ready_o <= 1'b0;
            psel_o    <= 1'b1;
            paddr_o   <= DATA_ADDR;
            pwdata_o  <= {16'h0000, s_data_i[15:0]};
            hi_q      <= s_data_i[31:16];
            hi_pend_q <= ~s_half_i;
            last_q    <= s_last_i;
            state_q   <= SETUP;
          end else begin
            s_ready_o <= en_i;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            gap_q     <= GAP_LOAD;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (gap_q != '0) gap_q <= gap_q - GW'(1);
        end
        default: state_q <= IDLE;
      endcase

      // Gap expiry: either launch the upper halfword or return to IDLE.
      if (exit_c) begin
        if (hi_pend_q) begin
          hi_pend_q <= 1'b0;
          pwdata_o  <= {16'h0000, hi_q};
          psel_o    <= 1'b1;
          state_q   <= SETUP;
        end else begin
          s_ready_o <= en_i;
          state_q   <= IDLE;
        end
      end
    end
  end

  // Status: done pulse, sticky error (new error beats clear), saturating count.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      wr_cnt_o <= '0;
    end else begin
      done_o <= done_set_c;
      if (xfer_done_c && pslverr_i) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
      if (xfer_done_c && (wr_cnt_o != '1)) begin
        wr_cnt_o <= wr_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_crc_apb4_feeder.sv
// Scoreboard bench for crc_apb4_feeder: directed beats push expected APB writes,
// a negedge monitor pops and compares each completed transfer.
module tb_crc_apb4_feeder;

  localparam logic [31:0] ADDR = 32'h0000_000C;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        en_i = 1'b1;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data_i = '0;
  logic        s_half_i = 1'b0;
  logic        s_last_i = 1'b0;
  logic [31:0] paddr_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic        pready_i = 1'b1;
  logic        pslverr_i = 1'b0;
  logic [31:0] prdata_i = '0;
  logic        busy_o, done_o, err_o;
  logic        err_clr_i = 1'b0;
  logic [15:0] wr_cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] exp_q[$];
  int          wr_cyc[$];
  int          done_cyc[$];

  crc_apb4_feeder #(.DATA_ADDR(ADDR), .GAP_CYCLES(3), .CNT_WIDTH(16)) dut (
    .pclk(pclk), .presetn(presetn), .en_i(en_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_half_i(s_half_i), .s_last_i(s_last_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .wr_cnt_o(wr_cnt_o)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed transfer must match the head of the expected queue.
  always @(negedge pclk) begin
    if (presetn && psel_o && penable_o && pready_i) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {paddr_o, pwdata_o}, 64'h0);
      end else begin
        chk("apb_write", {paddr_o, pwdata_o}, exp_q.pop_front());
      end
      chk("apb_const", {28'h0, pwrite_o, pstrb_o, pprot_o}, {28'h0, 1'b1, 4'hF, 3'h0});
    end
    if (presetn && done_o) done_cyc.push_back(cyc);
  end

  task automatic wait_cyc(input int n);
    int k = 0;
    do begin
      @(negedge pclk);
      k++;
    end while (cyc < n && k < 200);
    if (cyc != n) chk("wait_cyc_timeout", 64'(cyc), 64'(n));
  endtask

  task automatic do_reset();
    presetn = 1'b0; s_valid_i = 1'b0; pready_i = 1'b1; pslverr_i = 1'b0; err_clr_i = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_state", {psel_o, penable_o, s_ready_o, done_o, err_o, busy_o, paddr_o, pwdata_o, wr_cnt_o},
        '0);
    wr_cyc.delete();
    done_cyc.delete();
    presetn = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic h, input logic l, output int t);
    int k = 0;
    s_data_i = d; s_half_i = h; s_last_i = l; s_valid_i = 1'b1;
    do begin
      @(negedge pclk);
      k++;
    end while (!s_ready_o && k < 100);
    if (!s_ready_o) chk("accept_timeout", 64'(s_ready_o), 64'h1);
    t = cyc;
    @(posedge pclk);
    #1;
    s_valid_i = 1'b0;
  endtask

  initial begin
    int t, t2;

    // Full beat, last.
    do_reset();
    exp_q.push_back({ADDR, 32'h0000_1234});
    exp_q.push_back({ADDR, 32'h0000_BEEF});
    send_beat(32'hBEEF_1234, 1'b0, 1'b1, t);
    wait_cyc(t + 11);
    chk("full_ready_again", 64'(s_ready_o), 64'h1);
    chk("full_wr_cycles", {32'(wr_cyc.size()), 32'(wr_cyc[0] - t), 32'(wr_cyc[1] - t)},
        {32'd2, 32'd2, 32'd7});
    chk("full_done", {32'(done_cyc.size()), 32'(done_cyc[0] - t)}, {32'd1, 32'd10});
    chk("full_wr_cnt", 64'(wr_cnt_o), 64'd2);

    // Half beat.
    do_reset();
    exp_q.push_back({ADDR, 32'h0000_00A5});
    send_beat(32'hFFFF_00A5, 1'b1, 1'b1, t);
    wait_cyc(t + 6);
    chk("half_idle", {63'h0, busy_o}, 64'h0);
    chk("half_wr_cycles", {32'(wr_cyc.size()), 32'(wr_cyc[0] - t)}, {32'd1, 32'd2});
    chk("half_done", {32'(done_cyc.size()), 32'(done_cyc[0] - t)}, {32'd1, 32'd5});
    chk("half_wr_cnt", 64'(wr_cnt_o), 64'd1);

    // pready held low for three ACCESS cycles.
    do_reset();
    pready_i = 1'b0;
    exp_q.push_back({ADDR, 32'h0000_0077});
    exp_q.push_back({ADDR, 32'h0000_1100});
    send_beat(32'h1100_0077, 1'b0, 1'b1, t);
    for (int k = 2; k <= 4; k++) begin
      wait_cyc(t + k);
      chk("stall_hold", {30'h0, psel_o, penable_o, paddr_o}, {30'h0, 2'b11, ADDR});
      chk("stall_data", 64'(pwdata_o), 64'h0000_0077);
    end
    @(posedge pclk);
    #1;
    pready_i = 1'b1;
    wait_cyc(t + 6);
    chk("stall_wait_start", {62'h0, psel_o, busy_o}, 64'h1);
    wait_cyc(t + 14);
    chk("stall_wr_cycles", {32'(wr_cyc[0] - t), 32'(wr_cyc[1] - t)}, {32'd5, 32'd10});
    chk("stall_done", {32'(done_cyc.size()), 32'(done_cyc[0] - t)}, {32'd1, 32'd13});

    // Back-to-back beats, second is last.
    do_reset();
    exp_q.push_back({ADDR, 32'h0000_0001});
    exp_q.push_back({ADDR, 32'h0000_0000});
    exp_q.push_back({ADDR, 32'h0000_0002});
    exp_q.push_back({ADDR, 32'h0000_0000});
    send_beat(32'h0000_0001, 1'b0, 1'b0, t);
    send_beat(32'h0000_0002, 1'b0, 1'b1, t2);
    chk("b2b_second_accept", 64'(t2 - t), 64'd11);
    wait_cyc(t + 22);
    chk("b2b_wr_count", 64'(wr_cyc.size()), 64'd4);
    chk("b2b_wr_cycles", {16'(wr_cyc[0] - t), 16'(wr_cyc[1] - t), 16'(wr_cyc[2] - t), 16'(wr_cyc[3] - t)},
        {16'd2, 16'd7, 16'd13, 16'd18});
    chk("b2b_done", {32'(done_cyc.size()), 32'(done_cyc[0] - t)}, {32'd1, 32'd21});
    chk("b2b_wr_cnt", 64'(wr_cnt_o), 64'd4);

    // Slave error on the first write.
    do_reset();
    pslverr_i = 1'b1;
    exp_q.push_back({ADDR, 32'h0000_3344});
    exp_q.push_back({ADDR, 32'h0000_1122});
    send_beat(32'h1122_3344, 1'b0, 1'b1, t);
    wait_cyc(t + 2);
    @(posedge pclk);
    #1;
    pslverr_i = 1'b0;
    wait_cyc(t + 3);
    chk("err_set", 64'(err_o), 64'h1);
    wait_cyc(t + 11);
    chk("err_second_write", {32'(wr_cyc.size()), 32'(wr_cyc[1] - t)}, {32'd2, 32'd7});
    chk("err_sticky_cnt", {47'h0, err_o, wr_cnt_o}, {47'h0, 1'b1, 16'd2});
    @(posedge pclk);
    #1;
    err_clr_i = 1'b1;
    @(posedge pclk);
    #1;
    err_clr_i = 1'b0;
    @(negedge pclk);
    chk("err_cleared", 64'(err_o), 64'h0);

    // Reset asserted mid-ACCESS, then a clean restart.
    do_reset();
    pready_i = 1'b0;
    send_beat(32'h9999_8888, 1'b0, 1'b1, t);
    wait_cyc(t + 2);
    chk("rst_in_access", {62'h0, psel_o, penable_o}, 64'h3);
    #1;
    presetn = 1'b0;
    #1;
    chk("rst_async_drop", {61'h0, psel_o, penable_o, busy_o}, 64'h0);
    do_reset();
    exp_q.push_back({ADDR, 32'h0000_5A5A});
    send_beat(32'hABCD_5A5A, 1'b1, 1'b1, t);
    wait_cyc(t + 1);
    chk("rst_clean_setup", {30'h0, psel_o, penable_o, pwdata_o}, {30'h0, 2'b10, 32'h0000_5A5A});
    wait_cyc(t + 6);
    chk("rst_restart_done", {16'(wr_cyc.size()), 16'(done_cyc.size()), 16'(done_cyc[0] - t), wr_cnt_o},
        {16'd1, 16'd1, 16'd5, 16'd1});

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1);
  end

endmodule
